// File: rtl/key_tick_pkg.sv
// Shared defaults, FSM state encodings and the per-key event bundle for the
// run/pause/clear tick controller.
package key_tick_pkg;

  localparam int DIV_SLOW_DEFAULT        = 5_000_000;
  localparam int DIV_FAST_DEFAULT        = 1_000_000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 100_000;
  localparam int HOLD_CYCLES_DEFAULT     = 20_000_000;

  typedef logic [1:0] state_t;

  localparam state_t ST_PAUSED  = 2'd0;
  localparam state_t ST_RUNNING = 2'd1;
  localparam state_t ST_CLEAR   = 2'd2;

  typedef struct packed {
    logic level;
    logic press;
  } key_evt_t;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, counting debouncer and a registered
// one-cycle press pulse on a debounced 1->0 transition.
module key_debounce
  import key_tick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     key,
  output key_evt_t evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic             press;
  logic             vld;
  logic             armed;
  logic [CNT_W-1:0] cnt;

  // A key held across reset release must not produce a press, so presses are
  // only armed once a genuine released sample has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      level_q <= 1'b1;
      press   <= 1'b0;
      vld     <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: every register here samples the pre-edge values of the others;
      // non-blocking assignment is what makes the pipeline stages line up.
      sync1   <= key;
      sync2   <= sync1;
      vld     <= 1'b1;
      level_q <= level;
      press   <= armed & level_q & ~level;
      if (vld && sync1 && level) begin
        armed <= 1'b1;
      end
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign evt.level = level;
  assign evt.press = press;

endmodule

// File: rtl/key_tick_ctrl.sv
// Day-counter tick generator: KEY[0] toggles run/pause or clears on a long
// hold, KEY[1] toggles slow/fast tick rate.
module key_tick_ctrl
  import key_tick_pkg::*;
#(
  parameter int DIV_SLOW        = DIV_SLOW_DEFAULT,
  parameter int DIV_FAST        = DIV_FAST_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic [1:0] KEY,
  output logic       tick,
  output logic       clear,
  output logic       run,
  output logic       fast
);

  localparam int DIV_W  = $clog2(DIV_SLOW);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [DIV_W-1:0]  LAST_SLOW = DIV_W'(DIV_SLOW - 1);
  localparam logic [DIV_W-1:0]  LAST_FAST = DIV_W'(DIV_FAST - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  key_evt_t          keys [2];
  state_t            state;
  state_t            state_nxt;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_last;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              hold_fire;
  logic              run_press;
  logic              speed_press;

  for (genvar i = 0; i < 2; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk  (ADC_CLK_10),
      .reset(reset),
      .key  (KEY[i]),
      .evt  (keys[i])
    );
  end

  assign run_press   = keys[0].press;
  assign speed_press = keys[1].press;

  // The hold timer fires once per debounced low period and re-arms only
  // after a debounced release.
  assign hold_fire = ~keys[0].level & ~hold_done & (hold_cnt == HOLD_LAST);

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (keys[0].level) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
    end else if (hold_fire) begin
      hold_cnt  <= '0;
      hold_done <= 1'b1;
    end else if (!hold_done) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    case (state)
      ST_PAUSED, ST_RUNNING: begin
        if (hold_fire) begin
          state_nxt = ST_CLEAR;
        end else if (run_press) begin
          state_nxt = (state == ST_RUNNING) ? ST_PAUSED : ST_RUNNING;
        end
      end
      default: state_nxt = ST_PAUSED;
    endcase
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      state <= ST_PAUSED;
    end else begin
      state <= state_nxt;
    end
  end

  assign div_last = fast ? LAST_FAST : LAST_SLOW;

  // Pausing simply stops the count, so a resumed period picks up where it
  // left off; a rate change always starts a fresh period.
  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      div <= '0;
    end else if (state == ST_CLEAR || speed_press) begin
      div <= '0;
    end else if (state == ST_RUNNING) begin
      div <= (div == div_last) ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      fast <= 1'b0;
    end else if (speed_press) begin
      fast <= ~fast;
    end
  end

  assign run   = (state == ST_RUNNING);
  assign clear = (state == ST_CLEAR);
  assign tick  = run & (div == div_last) & ~speed_press;

endmodule
